// File: rtl/elevator_pkg.sv
// Shared constants and state encoding for the elevator call scheduler.
package elevator_pkg;

    localparam logic UP = 1'b0;
    localparam logic DO = 1'b1;

    localparam int NFLOORS_DEF = 4;
    localparam int FLOOR_W_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } state_t;

endpackage

// File: rtl/elevator_req_lookahead.sv
// Combinational view of the pending calls relative to a given floor.
module elevator_req_lookahead
    import elevator_pkg::*;
#(
    parameter int NFLOORS = NFLOORS_DEF,
    parameter int FLOOR_W = FLOOR_W_DEF
)(
    input  logic [NFLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0] floor,
    output logic               any_above,
    output logic               any_below,
    output logic               here
);

    always_comb begin
        any_above = 1'b0;
        any_below = 1'b0;
        here      = 1'b0;
        for (int i = 0; i < NFLOORS; i++) begin
            if (pending[i] && (FLOOR_W'(i) > floor))  any_above = 1'b1;
            if (pending[i] && (FLOOR_W'(i) < floor))  any_below = 1'b1;
            if (pending[i] && (FLOOR_W'(i) == floor)) here      = 1'b1;
        end
    end

endmodule

// File: rtl/elevator_sched.sv
// SCAN-style call scheduler and car sequencer for the elevator.
// Optional: define DOOR_REOPEN_EN so a call at the open floor restarts the door timer.
module elevator_sched
    import elevator_pkg::*;
#(
    parameter int NFLOORS     = NFLOORS_DEF,
    parameter int FLOOR_W     = FLOOR_W_DEF,
    parameter int MOVE_CYCLES = 16,
    parameter int DOOR_CYCLES = 8
)(
    input  logic               clk,
    input  logic               rst,
    input  logic [NFLOORS-1:0] call_req,
    output logic [FLOOR_W-1:0] floor,
    output logic               dir,
    output logic               moving,
    output logic               door_open,
    output logic [NFLOORS-1:0] pending,
    output logic               arrive
);

    localparam int MT_W = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
    localparam int DT_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [MT_W-1:0]    MOVE_LOAD = MT_W'(MOVE_CYCLES - 1);
    localparam logic [DT_W-1:0]    DOOR_LOAD = DT_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NFLOORS - 1);

    // Saturating one-floor step; the lookahead should never ask past the ends.
    function automatic logic [FLOOR_W-1:0] step_floor(input logic [FLOOR_W-1:0] f,
                                                      input logic d);
        if (d == UP)
            return (f == TOP_FLOOR) ? f : f + FLOOR_W'(1);
        return (f == '0) ? f : f - FLOOR_W'(1);
    endfunction

    function automatic logic [NFLOORS-1:0] onehot(input logic [FLOOR_W-1:0] f);
        return NFLOORS'(1) << f;
    endfunction

    state_t              state, state_n;
    logic [MT_W-1:0]     move_tmr, move_tmr_n;
    logic [DT_W-1:0]     door_tmr, door_tmr_n;
    logic [FLOOR_W-1:0]  floor_n, nf;
    logic                dir_n, arrive_n;
    logic [NFLOORS-1:0]  serve_mask, pending_n;
    logic                above_now, below_now, here_now;
    logic                above_nf, below_nf, here_nf, ahead_nf;

    assign nf       = step_floor(floor, dir);
    assign ahead_nf = (dir == UP) ? above_nf : below_nf;

    elevator_req_lookahead #(.NFLOORS(NFLOORS), .FLOOR_W(FLOOR_W)) u_look_now (
        .pending   (pending),
        .floor     (floor),
        .any_above (above_now),
        .any_below (below_now),
        .here      (here_now)
    );

    elevator_req_lookahead #(.NFLOORS(NFLOORS), .FLOOR_W(FLOOR_W)) u_look_next (
        .pending   (pending),
        .floor     (nf),
        .any_above (above_nf),
        .any_below (below_nf),
        .here      (here_nf)
    );

    always_comb begin
        state_n    = state;
        floor_n    = floor;
        dir_n      = dir;
        move_tmr_n = move_tmr;
        door_tmr_n = door_tmr;
        arrive_n   = 1'b0;
        serve_mask = '0;
        case (state)
            IDLE: begin
                if (here_now) begin
                    state_n    = DOOR;
                    serve_mask = onehot(floor);
                    door_tmr_n = DOOR_LOAD;
                end else if (above_now && (dir == UP || !below_now)) begin
                    state_n    = MOVE;
                    dir_n      = UP;
                    move_tmr_n = MOVE_LOAD;
                end else if (below_now) begin
                    state_n    = MOVE;
                    dir_n      = DO;
                    move_tmr_n = MOVE_LOAD;
                end
            end
            MOVE: begin
                if (move_tmr != '0) begin
                    move_tmr_n = move_tmr - MT_W'(1);
                end else begin
                    floor_n  = nf;
                    arrive_n = 1'b1;
                    if (here_nf) begin
                        state_n    = DOOR;
                        serve_mask = onehot(nf);
                        door_tmr_n = DOOR_LOAD;
                    end else if (ahead_nf) begin
                        move_tmr_n = MOVE_LOAD;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            DOOR: begin
                // The open floor is served continuously, so its calls never latch.
                serve_mask = onehot(floor);
`ifdef DOOR_REOPEN_EN
                if ((call_req & onehot(floor)) != '0)
                    door_tmr_n = DOOR_LOAD;
                else if (door_tmr == '0)
                    state_n = IDLE;
                else
                    door_tmr_n = door_tmr - DT_W'(1);
`else
                if (door_tmr == '0)
                    state_n = IDLE;
                else
                    door_tmr_n = door_tmr - DT_W'(1);
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    assign pending_n = (pending | call_req) & ~serve_mask;
    assign moving    = (state == MOVE);
    assign door_open = (state == DOOR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            floor    <= '0;
            dir      <= UP;
            pending  <= '0;
            arrive   <= 1'b0;
            move_tmr <= '0;
            door_tmr <= '0;
        end else begin
            state    <= state_n;
            floor    <= floor_n;
            dir      <= dir_n;
            pending  <= pending_n;
            arrive   <= arrive_n;
            move_tmr <= move_tmr_n;
            door_tmr <= door_tmr_n;
        end
    end

endmodule
